// File: rtl/count_pkg.sv
// count_pkg: shared types and default sizing for the preset loader.
//   state_t             - loader FSM states
//   DATA_W_DEF          - default preset width
//   PRESC_LOG2_MAX_DEF  - default largest prescaler exponent
package count_pkg;

    localparam int DATA_W_DEF         = 8;
    localparam int PRESC_LOG2_MAX_DEF = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous pin, plus one
// history flop for edge detection.
//   clk, rst_n - clock, asynchronous active-low reset
//   d          - asynchronous input pin
//   level      - synchronised level
//   rise, fall - one-cycle pulses on synchronised rising / falling edges
// All flops reset to RST_VAL so no spurious edge appears after reset.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample pre-edge values and the chain shifts by exactly one per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/count_preset_loader.sv
// count_preset_loader: upstream control stage for the programmable counter.
// Receives a DATA_W-bit preset over a 3-wire serial link and presents it as
// a one-cycle load pulse plus data; also produces a power-of-two prescaled
// count-enable tick.
//   clk, rst_n       - clock, asynchronous active-low reset
//   ena              - block enable; 0 holds all state and gates load/cnt_en
//   cs_n, sclk, sdi  - asynchronous serial frame select, bit clock, data
//   run              - enables the prescaler
//   presc_sel        - tick period exponent (clamped to PRESC_LOG2_MAX)
//   load, load_data  - one-cycle load pulse and the committed preset
//   cnt_en           - count tick to the counter
//   busy             - frame in progress (SHIFT or COMMIT)
//   frame_err        - sticky: last frame had the wrong bit count
module count_preset_loader
    import count_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int PRESC_LOG2_MAX = PRESC_LOG2_MAX_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    input  logic              run,
    input  logic [3:0]        presc_sel,
    output logic              load,
    output logic [DATA_W-1:0] load_data,
    output logic              cnt_en,
    output logic              busy,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] BIT_SAT  = CNT_W'(DATA_W + 1);
    localparam logic [3:0]       SEL_MAX  = 4'(PRESC_LOG2_MAX);

    // Synchronised serial pins. Edge pulses last one cycle and are simply
    // ignored when ena=0, so edges seen while disabled are never replayed.
    logic unused_cs_level, cs_rise, cs_fall;
    logic unused_sclk_level, sclk_rise, unused_sclk_fall;
    logic sdi_s, unused_sdi_rise, unused_sdi_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n),
        .level(unused_cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(unused_sclk_level), .rise(sclk_rise), .fall(unused_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .d(sdi),
        .level(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
    );

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         shreg_q;
    logic [CNT_W-1:0]          bitcnt_q;
    logic [PRESC_LOG2_MAX-1:0] p_q, mask;
    logic [3:0]                sel_q;
    logic                      start_frame, shift_bit, commit_frame, bad_frame;

    // Next-state and per-cycle action flags. A cs_n rise takes priority over
    // an sclk rise in the same cycle, so that sclk edge is dropped.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        start_frame  = 1'b0;
        shift_bit    = 1'b0;
        commit_frame = 1'b0;
        bad_frame    = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d     = SHIFT;
                        start_frame = 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bitcnt_q == BIT_FULL) begin
                            state_d      = COMMIT;
                            commit_frame = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            bad_frame = 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_bit = 1'b1;
                    end
                end
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath. load_data is written on the transition into COMMIT so
    // it is already valid during the load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            load_data <= '0;
            frame_err <= 1'b0;
        end else begin
            if (start_frame) begin
                bitcnt_q  <= '0;
                frame_err <= 1'b0;
            end
            if (shift_bit) begin
                shreg_q <= {shreg_q[DATA_W-2:0], sdi_s};
                if (bitcnt_q != BIT_SAT) begin
                    bitcnt_q <= bitcnt_q + 1'b1;
                end
            end
            if (commit_frame) begin
                load_data <= shreg_q;
            end
            if (bad_frame) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign load = ena & (state_q == COMMIT);
    assign busy = (state_q != IDLE);

    // Prescaler. presc_sel is registered (clamped) so a change applies from
    // the next cycle and cnt_en has no path from that pin. The load cycle
    // restarts the count so the first tick lands a full period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            p_q   <= '0;
        end else if (ena) begin
            sel_q <= (presc_sel > SEL_MAX) ? SEL_MAX : presc_sel;
            if (load) begin
                p_q <= '0;
            end else if (run) begin
                p_q <= p_q + 1'b1;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PRESC_LOG2_MAX; i++) begin
            mask[i] = (i < int'(sel_q));
        end
    end

    assign cnt_en = ena & run & ((p_q & mask) == mask) & ~load;

endmodule
